// File: rtl/imm_encoder_if.sv
// Request/result bus of the immediate encoder: a valid/ready request channel carrying
// format, immediate and base word, and a valid/ready result channel.
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [31:0] in_imm;
  logic [31:0] in_base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;

  modport slave (
    input  in_valid, in_fmt, in_imm, in_base, out_ready,
    output in_ready, out_valid, out_inst, out_err
  );

  modport master (
    output in_valid, in_fmt, in_imm, in_base, out_ready,
    input  in_ready, out_valid, out_inst, out_err
  );
endinterface

// File: rtl/imm_encoder.sv
// RISC-V immediate encoder: scatters an immediate into I/S/B/U/J instruction bit
// positions of a base word, range-checks it, and returns the result through two stages.
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  imm_encoder_if.slave     bus,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_S = 3'd1;
  localparam logic [2:0] FMT_B = 3'd2;
  localparam logic [2:0] FMT_U = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;

  logic        s1_valid_q, s1_valid_d;
  logic [2:0]  s1_fmt_q,   s1_fmt_d;
  logic [31:0] s1_imm_q,   s1_imm_d;
  logic [31:0] s1_base_q,  s1_base_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_inst_q,  out_inst_d;
  logic        out_err_q,   out_err_d;

  logic        in_rdy;
  logic        in_hs;
  logic        out_hs;
  logic        s2_adv;
  logic [31:0] enc_inst;
  logic        enc_err;

  // Stage 1 may refill in the same cycle it drains into stage 2.
  assign in_rdy = !s1_valid_q | !out_valid_q | bus.out_ready;
  assign in_hs  = bus.in_valid & in_rdy;
  assign out_hs = out_valid_q & bus.out_ready;
  assign s2_adv = s1_valid_q & (!out_valid_q | bus.out_ready);

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_valid_q;
  assign bus.out_inst  = out_inst_q;
  assign bus.out_err   = out_err_q;

  always_comb begin
    enc_inst = s1_base_q;
    enc_err  = 1'b0;
    case (s1_fmt_q)
      FMT_I: begin
        enc_inst[31:20] = s1_imm_q[11:0];
        enc_err = s1_imm_q != {{20{s1_imm_q[11]}}, s1_imm_q[11:0]};
      end
      FMT_S: begin
        enc_inst[31:25] = s1_imm_q[11:5];
        enc_inst[11:7]  = s1_imm_q[4:0];
        enc_err = s1_imm_q != {{20{s1_imm_q[11]}}, s1_imm_q[11:0]};
      end
      FMT_B: begin
        enc_inst[31]    = s1_imm_q[12];
        enc_inst[30:25] = s1_imm_q[10:5];
        enc_inst[11:8]  = s1_imm_q[4:1];
        enc_inst[7]     = s1_imm_q[11];
        enc_err = (s1_imm_q != {{19{s1_imm_q[12]}}, s1_imm_q[12:0]}) | s1_imm_q[0];
      end
      FMT_U: begin
        enc_inst[31:12] = s1_imm_q[31:12];
        enc_err = s1_imm_q[11:0] != 12'd0;
      end
      FMT_J: begin
        enc_inst[31]    = s1_imm_q[20];
        enc_inst[30:21] = s1_imm_q[10:1];
        enc_inst[20]    = s1_imm_q[11];
        enc_inst[19:12] = s1_imm_q[19:12];
        enc_err = (s1_imm_q != {{11{s1_imm_q[20]}}, s1_imm_q[20:0]}) | s1_imm_q[0];
      end
      default: begin
        enc_err = 1'b1;
      end
    endcase
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_fmt_d    = s1_fmt_q;
    s1_imm_d    = s1_imm_q;
    s1_base_d   = s1_base_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_err_d   = out_err_q;
    if (s2_adv) begin
      s1_valid_d = 1'b0;
    end
    if (in_hs) begin
      s1_valid_d = 1'b1;
      s1_fmt_d   = bus.in_fmt;
      s1_imm_d   = bus.in_imm;
      s1_base_d  = bus.in_base;
    end
    if (out_hs) begin
      out_valid_d = 1'b0;
    end
    if (s2_adv) begin
      out_valid_d = 1'b1;
      out_inst_d  = enc_inst;
      out_err_d   = enc_err;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_q  <= 1'b0;
      s1_fmt_q    <= 3'd0;
      s1_imm_q    <= 32'd0;
      s1_base_q   <= 32'd0;
      out_valid_q <= 1'b0;
      out_inst_q  <= 32'd0;
      out_err_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_fmt_q    <= s1_fmt_d;
      s1_imm_q    <= s1_imm_d;
      s1_base_q   <= s1_base_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_err_q   <= out_err_d;
    end
  end

  // Counter 0 counts every delivered result, counter 1 only the erroneous ones.
  logic [1:0] cnt_inc;
  assign cnt_inc = {out_hs & out_err_q, out_hs};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (cnt_inc[gi] && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign enc_count = g_cnt[0].cnt_q;
  assign err_count = g_cnt[1].cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Randomized and directed bench for imm_encoder, scored against an arithmetic
// reference model of the encoding, range rules, pipeline occupancy and counters.
module tb_imm_encoder;

  localparam int CNT_W = 16;

  logic             CLK;
  logic             RST;
  logic [CNT_W-1:0] enc_count;
  logic [CNT_W-1:0] err_count;

  imm_encoder_if bus ();

  imm_encoder #(.CNT_W(CNT_W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic [31:0] base;
    int          acc;
  } req_t;

  req_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          accepted;
  bit          verbose = 1'b1;
  longint      exp_enc = 0;
  longint      exp_err = 0;
  logic [31:0] last_inst;
  logic        last_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: representable range in plain signed arithmetic.
  function automatic bit model_err(input logic [2:0] fmt, input logic [31:0] imm);
    longint s;
    s = longint'($signed(imm));
    case (fmt)
      3'd0, 3'd1: return (s < -2048) || (s > 2047);
      3'd2:       return (s < -4096) || (s > 4095) || ((s % 2) != 0);
      3'd3:       return (imm % 4096) != 0;
      3'd4:       return (s < -1048576) || (s > 1048575) || ((s % 2) != 0);
      default:    return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] model_inst(input logic [2:0] fmt, input logic [31:0] imm,
                                             input logic [31:0] b);
    case (fmt)
      3'd0:    return {imm[11:0], b[19:0]};
      3'd1:    return {imm[11:5], b[24:12], imm[4:0], b[6:0]};
      3'd2:    return {imm[12], imm[10:5], b[24:12], imm[4:1], imm[11], b[6:0]};
      3'd3:    return {imm[31:12], b[11:0]};
      3'd4:    return {imm[20], imm[10:1], imm[11], imm[19:12], b[11:0]};
      default: return b;
    endcase
  endfunction

  // Independent decoder used for the round-trip property.
  function automatic logic [31:0] decode(input logic [2:0] fmt, input logic [31:0] inst);
    longint v;
    case (fmt)
      3'd0: begin
        v = inst[31:20];
        if (v >= 2048) v -= 4096;
      end
      3'd1: begin
        v = inst[31:25] * 32 + inst[11:7];
        if (v >= 2048) v -= 4096;
      end
      3'd2: begin
        v = inst[31] * 4096 + inst[7] * 2048 + inst[30:25] * 32 + inst[11:8] * 2;
        if (v >= 4096) v -= 8192;
      end
      3'd3: v = inst & 32'hFFFFF000;
      default: begin
        v = inst[31] * 1048576 + inst[19:12] * 4096 + inst[20] * 2048 + inst[30:21] * 2;
        if (v >= 1048576) v -= 2097152;
      end
    endcase
    return 32'(v);
  endfunction

  // Evaluate one cycle: inputs are already set after the falling edge.
  task automatic step();
    req_t r;
    logic [31:0] ei;
    logic ee;
    #1;
    accepted = 1'b0;
    check("in_ready", bus.in_ready, (q.size() < 2) || bus.out_ready);
    check("out_valid", bus.out_valid, (q.size() > 0) && (cyc >= q[0].acc + 2));
    check("enc_count", enc_count, exp_enc);
    check("err_count", err_count, exp_err);
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        check("sb_nonempty", q.size(), 1);
      end else begin
        r  = q.pop_front();
        ei = model_inst(r.fmt, r.imm, r.base);
        ee = model_err(r.fmt, r.imm);
        check("out_inst", bus.out_inst, ei);
        check("out_err", bus.out_err, ee);
        if (!ee && r.fmt <= 3'd4) check("roundtrip", decode(r.fmt, bus.out_inst), r.imm);
        last_inst = bus.out_inst;
        last_err  = bus.out_err;
        if (exp_enc < 65535) exp_enc++;
        if (ee && exp_err < 65535) exp_err++;
        if (verbose)
          $display("txn fmt=%0d imm=%h base=%h -> inst=%h err=%0d",
                   r.fmt, r.imm, r.base, bus.out_inst, bus.out_err);
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      r.fmt  = bus.in_fmt;
      r.imm  = bus.in_imm;
      r.base = bus.in_base;
      r.acc  = cyc;
      q.push_back(r);
      accepted = 1'b1;
    end
    @(negedge CLK);
    cyc++;
  endtask

  task automatic drive(input logic [2:0] fmt, input logic [31:0] imm, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.in_fmt   = fmt;
    bus.in_imm   = imm;
    bus.in_base  = b;
  endtask

  task automatic send(input logic [2:0] fmt, input logic [31:0] imm, input logic [31:0] b);
    drive(fmt, imm, b);
    for (int i = 0; i < 20; i++) begin
      step();
      if (accepted) break;
    end
    if (!accepted) check("send_timeout", accepted, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      step();
    end
    check("drain_timeout", q.size(), 0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(negedge CLK);
    cyc++;
    RST = 1'b0;
    bus.in_valid = 1'b0;
    q.delete();
    exp_enc = 0;
    exp_err = 0;
  endtask

  function automatic logic [31:0] rand_imm();
    case ($urandom % 5)
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 8191)) - 32'd4096;
      2:       return 32'($urandom_range(0, 4194303)) - 32'd2097152;
      3:       return $urandom & 32'hFFFFF000;
      default: return 32'($urandom_range(0, 4095)) - 32'd2048;
    endcase
  endfunction

  initial begin
    int base_enc;
    bit pending;
    RST = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_fmt    = 3'd0;
    bus.in_imm    = 32'd0;
    bus.in_base   = 32'd0;
    bus.out_ready = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_inst", bus.out_inst, 32'h0);
    check("rst_out_err", bus.out_err, 0);
    check("rst_enc_count", enc_count, 0);
    check("rst_err_count", err_count, 0);
    check("rst_in_ready", bus.in_ready, 1);
    RST = 1'b0;
    @(negedge CLK);

    // I format
    send(3'd0, 32'hFFFFF800, 32'h00000013); drain();
    check("I_inst", last_inst, 32'h80000013);
    check("I_err", last_err, 0);
    send(3'd0, 32'h00000800, 32'h00000013); drain();
    check("I_range_err", last_err, 1);

    // B format from a clean counter state
    do_reset();
    send(3'd2, 32'h00000FFE, 32'h00000063); drain();
    check("B_inst", last_inst, 32'h7E000FE3);
    check("B_err", last_err, 0);
    send(3'd2, 32'h00001001, 32'h00000063); drain();
    check("B_range_err", last_err, 1);
    step();
    check("B_err_count", err_count, 1);

    // U and J formats
    send(3'd3, 32'h12345000, 32'h00000037); drain();
    check("U_inst", last_inst, 32'h12345037);
    check("U_err", last_err, 0);
    send(3'd3, 32'h12345001, 32'h00000037); drain();
    check("U_inst_lowbits", last_inst, 32'h12345037);
    check("U_err_lowbits", last_err, 1);
    send(3'd4, 32'hFFFFFFFE, 32'h0000006F); drain();
    check("J_inst", last_inst, 32'hFFFFF06F);
    check("J_err", last_err, 0);

    // Illegal format
    send(3'd6, 32'h00000004, 32'hDEADBEEF); drain();
    check("ILL_inst", last_inst, 32'hDEADBEEF);
    check("ILL_err", last_err, 1);

    // Backpressure: two held, third refused, then one per cycle in order
    step();
    base_enc = int'(enc_count);
    bus.out_ready = 1'b0;
    send(3'd1, 32'h00000010, 32'h00000023);
    send(3'd1, 32'h00000020, 32'h00000023);
    drive(3'd1, 32'h00000030, 32'h00000023);
    step();
    check("bp_third_refused", accepted, 0);
    bus.out_ready = 1'b1;
    step();
    check("bp_third_accept", accepted, 1);
    bus.in_valid = 1'b0;
    step();
    step();
    check("bp_drained", q.size(), 0);
    step();
    check("bp_enc_count", enc_count, base_enc + 3);

    // Reset while stalled with both stages full, request pending
    bus.out_ready = 1'b0;
    send(3'd0, 32'h00000001, 32'h00000013);
    send(3'd0, 32'h00000002, 32'h00000013);
    drive(3'd0, 32'h00000003, 32'h00000013);
    step();
    check("stall_full", accepted, 0);
    do_reset();
    #1;
    check("rst2_out_valid", bus.out_valid, 0);
    check("rst2_enc_count", enc_count, 0);
    check("rst2_err_count", err_count, 0);
    check("rst2_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    step();

    // Randomized traffic with random backpressure
    pending = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!pending) begin
        if (($urandom % 4) != 0) begin
          drive(3'($urandom_range(0, 7)), rand_imm(), $urandom);
          pending = 1'b1;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      bus.out_ready = ($urandom % 10) < 7;
      step();
      if (accepted) begin
        pending = 1'b0;
        bus.in_valid = 1'b0;
      end
    end
    drain();

    // Counter saturation with continuous traffic
    verbose = 1'b0;
    drive(3'd0, 32'd0, 32'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 65540; i++) step();
    drain();
    step();
    check("enc_sat", enc_count, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Pipelined RISC-V immediate encoder: the inverse of the MCU's immediate decode path. It accepts a 32-bit immediate, a format code and a base instruction word. It scatters the immediate into the format's instruction bit positions and range-checks it. The result is emitted through a two-stage valid/ready pipeline. It sits between the debug/program-loader path and instruction memory, and lets the loader patch branch, jump and load offsets into instruction words.

## Interface
Parameters:
- CNT_W, 16, width of the saturating encode and error counters

Ports:
- CLK  in  1  system clock; all state changes on rising edge
- RST  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept the request this cycle
- in_fmt  in  3  0=I, 1=S, 2=B, 3=U, 4=J, 5–7 illegal
- in_imm  in  32  immediate value (two's complement byte offset for B/J)
- in_base  in  32  instruction word; non-immediate bits are copied through
- out_valid  out  1  encoded result present
- out_ready  in  1  consumer accepts the result
- out_inst  out  32  encoded instruction
- out_err  out  1  immediate not representable, or illegal format
- enc_count  out  CNT_W  results delivered (output handshakes)
- err_count  out  CNT_W  delivered results with out_err=1

## Operation
- Stage 1 registers fmt, imm and base on an input handshake (in_valid & in_ready).
- Stage 2 registers the encoded word and err computed from the stage 1 contents.
- Bit mapping (all bits not listed are copied from base):
  - I: inst[31:20]=imm[11:0]
  - S: inst[31:25]=imm[11:5]; inst[11:7]=imm[4:0]
  - B: inst[31]=imm[12]; inst[30:25]=imm[10:5]; inst[11:8]=imm[4:1]; inst[7]=imm[11]
  - U: inst[31:12]=imm[31:12]
  - J: inst[31]=imm[20]; inst[30:21]=imm[10:1]; inst[20]=imm[11]; inst[19:12]=imm[19:12]
- Error rules:
  - I/S: err when imm differs from the sign-extension of imm[11:0]
  - B: err when imm differs from the sign-extension of imm[12:0], or imm[0]=1
  - J: err when imm differs from the sign-extension of imm[20:0], or imm[0]=1
  - U: err when imm[11:0]≠0
  - fmt 5–7: err=1 and out_inst=base unchanged
- On error the truncated encoding is still emitted. Nothing is dropped.
- Round-trip property: for err=0, decoding out_inst with the matching immediate format returns in_imm exactly.
- Counters:
  - enc_count increments on every output handshake (out_valid & out_ready).
  - err_count increments on an output handshake when out_err=1.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset (RST high at a clock edge):
  - out_valid=0, out_inst=0x00000000, out_err=0, enc_count=0, err_count=0, stage 1 valid=0.
  - Reset takes priority over any simultaneous handshake. In-flight requests are discarded.
- in_ready is combinational: in_ready = !s1_valid | !out_valid | out_ready. It does not depend on in_valid.
- Stage 1 advances into stage 2 when s1_valid & (!out_valid | out_ready).
- Latency: a request accepted at edge N appears with out_valid=1 after edge N+1 (two registers, no stall).
- Throughput: one result per cycle with out_ready held high.
- Simultaneous output and input handshakes in the same cycle: both occur; no bubble is inserted.
- Stall:
  - With out_ready=0, at most two requests are held (stage 1 + stage 2).
  - in_ready drops once both stages are full.
  - out_inst and out_err stay stable while out_valid=1 and out_ready=0.
- Ordering is strictly FIFO.

## Test plan
- I encoding: fmt=0, imm=0xFFFFF800, base=0x00000013 → out_inst=0x80000013, err=0, out_valid one edge after acceptance; imm=0x00000800 → err=1.
- B encoding: fmt=2, imm=0x00000FFE, base=0x00000063 → 0x7E000FE3, err=0; imm=0x00001001 → err=1; err_count=1.
- U/J encoding:
  - fmt=3, imm=0x12345000, base=0x00000037 → 0x12345037, err=0.
  - fmt=3, imm=0x12345001 → 0x12345037, err=1.
  - fmt=4, imm=0xFFFFFFFE, base=0x0000006F → 0xFFFFF06F, err=0.
- Backpressure: three back-to-back requests with out_ready=0 → two accepted, in_ready=0 on the third. Raising out_ready delivers all three in order, one per cycle; enc_count=3.
- Illegal fmt=6, base=0xDEADBEEF → out_inst=0xDEADBEEF, err=1.
- Reset while stalled with 2 entries → out_valid=0 and counters 0 on the next cycle, in_ready=1.
- Counter saturation: preload or drive 2^CNT_W+2 handshakes → enc_count holds 0xFFFF.
